aes_key_expander: RTL and testbench
===================================

// Module: aes_key_expander
// PURPOSE
//  Iterative AES key-schedule engine (FIPS-197 KeyExpansion) for 128/192/256-bit keys.
//  Produces the 1920-bit expanded-key bus consumed by the forward and inverse round-key
//  selectors (invKeyControl). Computes one 32-bit word per clock; start/busy/done handshake.
// PARAMETERS
//  none; all sizes fixed by AES (max 60 words = 1920 bits)
// PORTS
//  clk       in   1     rising-edge clock
//  rst       in   1     reset, asynchronous, active-high
//  start     in   1     begin expansion; sampled only in IDLE
//  key_size  in   3     3'b001=128, 3'b010=192, 3'b100=256; any other value = 128
//  key_in    in   256   [0:255] cipher key, MSB-first; 128-bit uses [0:127], 192-bit uses [0:191]
//  busy      out  1     high in LOAD and EXPAND
//  done      out  1     one-cycle pulse: key_exp complete
//  key_exp   out  1920  [0:1919] word w[i] at bits [32*i : 32*i+31]
// BEHAVIOUR
//  Reset: state=IDLE; busy=0; done=0; key_exp=0; internal counters and rcon cleared.
//  Nk/total words T: 128 -> 4/44, 192 -> 6/52, 256 -> 8/60.
//  FSM IDLE -> LOAD -> EXPAND -> DONE -> IDLE.
//   IDLE:   start=1 at edge k: latch key_size and key_in; go to LOAD.
//   LOAD:   edge k+1: clear all 60 words; write w[0..Nk-1] from key; i=Nk, j=0, rcon=8'h01.
//   EXPAND: each edge: temp=w[i-1].
//           j==0              -> temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; rcon=xtime(rcon)
//           Nk==8 and j==4    -> temp = SubWord(temp)
//           w[i] = w[i-Nk] ^ temp; i++; j = (j==Nk-1) ? 0 : j+1
//           After writing w[T-1], go to DONE and assert done.
//   DONE:   done=1 for exactly one cycle; next edge -> IDLE, done=0.
//  Latency: start-sample edge to done-high edge = 41 (128) / 47 (192) / 53 (256) cycles.
//  Unused words (i >= T) read zero after every run.
//  No divider: j replaces i mod Nk. rcon is an 8-bit register doubled in GF(2^8)
//   (0x80 -> 0x1B), giving 01,02,04,08,10,20,40,80,1B,36.
//  key_exp changes only in LOAD and EXPAND. It holds stable from done until the next LOAD.
//   Consumers must not sample it while busy=1.
//  start while busy=1 or in DONE: ignored. No queueing.
//  key_size and key_in changes after the start edge: no effect (latched copies used).
//  rst mid-run (any state): immediate return to IDLE with reset values; no done pulse.
//  start held high continuously: a new run starts on each IDLE visit (back-to-back, 1 idle cycle).
// STRUCTURE
//  aes_pkg: KEY128/KEY192/KEY256 encodings; NK_* and TOTAL_WORDS_* constants;
//   state enum (IDLE, LOAD, EXPAND, DONE); xtime function.
//  Sub-module aes_sbox: combinational 8-bit forward S-box; 4 instances form SubWord.
//   Shared with the encryption datapath.
//  Top: FSM, i (6-bit), j (3-bit), rcon (8-bit), 60x32 word register array,
//   read muxes for w[i-1] and w[i-Nk].
// TESTING
//  1 FIPS-197 A.1: key 2b7e1516 28aed2a6 abf71588 09cf4f3c, size 001
//    -> w[4]=a0fafe17, w[43]=b6630ca6; done at start+41; w[44..59]=0.
//  2 FIPS-197 A.2: key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b, size 010
//    -> w[6]=fe0c91f7, w[51]=01002202; done at start+47.
//  3 FIPS-197 A.3: key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7
//    2d9810a3 0914dff4, size 100
//    -> w[8]=9ba35411, w[12]=a8b09c1a (SubWord-only path), w[59]=706c631e; done at start+53.
//  4 Illegal size 3'b111 with the A.1 key -> key_exp identical to scenario 1.
//  5 Start A.3; pulse start with the A.1 key at cycle 10 (ignored)
//    -> A.3 result, single done pulse.
//  6 Start A.1; assert rst at cycle 20 -> busy=0, done=0, key_exp=0 next cycle.
//    Then rerun A.2 -> correct result, no stale A.1 words.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM state type and small GF(2^8) helpers.
package aes_pkg;

  localparam logic [2:0] KEY128 = 3'b001;
  localparam logic [2:0] KEY192 = 3'b010;
  localparam logic [2:0] KEY256 = 3'b100;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;

  localparam logic [5:0] TOTAL_WORDS_128 = 6'd44;
  localparam logic [5:0] TOTAL_WORDS_192 = 6'd52;
  localparam logic [5:0] TOTAL_WORDS_256 = 6'd60;

  localparam int MAX_WORDS = 60;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } stateT;

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Unrecognised key_size encodings fall back to 128-bit.
  function automatic logic [3:0] nkOf(input logic [2:0] sz);
    case (sz)
      KEY192:  return NK_192;
      KEY256:  return NK_256;
      default: return NK_128;
    endcase
  endfunction

  function automatic logic [5:0] totalOf(input logic [2:0] sz);
    case (sz)
      KEY192:  return TOTAL_WORDS_192;
      KEY256:  return TOTAL_WORDS_256;
      default: return TOTAL_WORDS_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] byteIn,
  output logic [7:0] byteOut
);

  // Row r of the table holds S[16r .. 16r+15], first entry in the leftmost byte.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table lookup.
  always_comb begin
    byteOut = SBOX[{byteIn, 3'b000} +: 8];
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key-schedule engine: one expanded word per clock for 128/192/256-bit keys.
//
// state  | meaning
// IDLE   | waiting for start; key and size latched on the start edge
// LOAD   | clear all words, copy the Nk key words, init i/j/rcon
// EXPAND | compute and write w[i] each cycle until w[T-1]
// DONE   | one-cycle done pulse, key_exp held stable
module aes_key_expander
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     key_size,
  input  logic [0:255]   key_in,
  output logic           busy,
  output logic           done,
  output logic [0:1919]  key_exp
);

  stateT        stateReg, stateNext;
  logic [0:255] keyReg;
  logic [3:0]   nkReg;
  logic [5:0]   totalReg;
  logic [5:0]   wordIdx;
  logic [2:0]   roundPos;
  logic [7:0]   rcon;
  logic [31:0]  words [0:MAX_WORDS-1];

  logic [5:0]   prevIdx, backIdx;
  logic [31:0]  prevWord, backWord, subIn, subOut, temp, newWord;
  logic         lastWord;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  // Next-state and handshake outputs.
  always_comb begin
    stateNext = stateReg;
    busy      = 1'b0;
    done      = 1'b0;
    case (stateReg)
      IDLE:   if (start) stateNext = LOAD;
      LOAD:   begin busy = 1'b1; stateNext = EXPAND; end
      EXPAND: begin busy = 1'b1; if (lastWord) stateNext = DONE; end
      DONE:   begin done = 1'b1; stateNext = IDLE; end
      default: stateNext = IDLE;
    endcase
  end

  // Latch key and size at the start edge so later input changes have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyReg   <= '0;
      nkReg    <= '0;
      totalReg <= '0;
    end else if (stateReg == IDLE && start) begin
      keyReg   <= key_in;
      nkReg    <= nkOf(key_size);
      totalReg <= totalOf(key_size);
    end
  end

  // Word index i, position j within the Nk group (replaces i mod Nk), and rcon.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordIdx  <= '0;
      roundPos <= '0;
      rcon     <= '0;
    end else if (stateReg == LOAD) begin
      wordIdx  <= {2'b00, nkReg};
      roundPos <= '0;
      rcon     <= 8'h01;
    end else if (stateReg == EXPAND) begin
      wordIdx  <= wordIdx + 6'd1;
      roundPos <= ({1'b0, roundPos} == nkReg - 4'd1) ? 3'd0 : roundPos + 3'd1;
      if (roundPos == 3'd0) rcon <= xtime(rcon);
    end
  end

  // Datapath for w[i] = w[i-Nk] ^ f(w[i-1]).
  always_comb begin
    prevIdx  = wordIdx - 6'd1;
    backIdx  = wordIdx - {2'b00, nkReg};
    prevWord = words[prevIdx];
    backWord = words[backIdx];
    subIn    = (roundPos == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;
    if (roundPos == 3'd0)                     temp = subOut ^ {rcon, 24'h0};
    else if (nkReg == NK_256 && roundPos == 3'd4) temp = subOut;
    else                                      temp = prevWord;
    newWord  = backWord ^ temp;
    lastWord = (wordIdx == totalReg - 6'd1);
  end

  for (genvar b = 0; b < 4; b++) begin : g_subWord
    aes_sbox uSbox (
      .byteIn  (subIn[8*b +: 8]),
      .byteOut (subOut[8*b +: 8])
    );
  end

  // Word array: cleared on LOAD so unused words read zero, one word written per EXPAND cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_WORDS; k++) words[k] <= '0;
    end else if (stateReg == LOAD) begin
      for (int k = 0; k < MAX_WORDS; k++) words[k] <= '0;
      for (int k = 0; k < 8; k++)
        if (4'(k) < nkReg) words[k] <= keyReg[32*k +: 32];
    end else if (stateReg == EXPAND) begin
      words[wordIdx] <= newWord;
    end
  end

  for (genvar k = 0; k < MAX_WORDS; k++) begin : g_keyExp
    assign key_exp[32*k +: 32] = words[k];
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for the AES key expander using FIPS-197 appendix A vectors.
module tb_aes_key_expander;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2:0]     key_size;
  logic [0:255]   key_in;
  logic           busy;
  logic           done;
  logic [0:1919]  key_exp;

  int compared   = 0;
  int mismatched = 0;

  aes_key_expander dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_size (key_size),
    .key_in   (key_in),
    .busy     (busy),
    .done     (done),
    .key_exp  (key_exp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]        size;
    logic [255:0]      key;
    logic [6:0]        lat;
    logic [6:0]        total;
    logic [3:0][5:0]   idx;
    logic [3:0][31:0]  expv;
  } vecT;

  localparam logic [255:0] K1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  vecT vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] getWord(input int n);
    return key_exp[32*n +: 32];
  endfunction

  function automatic logic [31:0] orFrom(input int first);
    logic [31:0] acc = '0;
    for (int n = first; n < 60; n++) acc |= getWord(n);
    return acc;
  endfunction

  task automatic pulseStart(input logic [2:0] sz, input logic [255:0] k);
    @(negedge clk);
    key_size = sz;
    key_in   = k;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    key_size = 3'b100;
    key_in   = '1;
  endtask

  task automatic runVec(input vecT v, input int tag);
    int cyc = 0;
    pulseStart(v.size, v.key);
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) break;
    end
    check($sformatf("v%0d done latency", tag), cyc, 32'(v.lat));
    check($sformatf("v%0d busy at done", tag), 32'(busy), 32'd0);
    for (int n = 0; n < 4; n++)
      check($sformatf("v%0d w[%0d]", tag, v.idx[n]), getWord(int'(v.idx[n])), v.expv[n]);
    check($sformatf("v%0d unused words", tag), orFrom(int'(v.total)), 32'd0);
    @(posedge clk);
    #1;
    check($sformatf("v%0d done width", tag), 32'(done), 32'd0);
    check($sformatf("v%0d hold w[%0d]", tag, v.idx[3]), getWord(int'(v.idx[3])), v.expv[3]);
  endtask

  initial begin
    int cyc, doneCnt, doneAt;

    vecs[0] = '{size: 3'b001, key: K1, lat: 7'd41, total: 7'd44,
                idx: {6'd43, 6'd42, 6'd40, 6'd4},
                expv: {32'hb6630ca6, 32'he13f0cc8, 32'hd014f9a8, 32'ha0fafe17}};
    vecs[1] = '{size: 3'b010, key: K2, lat: 7'd47, total: 7'd52,
                idx: {6'd51, 6'd50, 6'd48, 6'd6},
                expv: {32'h01002202, 32'h8ecc7204, 32'he98ba06f, 32'hfe0c91f7}};
    vecs[2] = '{size: 3'b100, key: K3, lat: 7'd53, total: 7'd60,
                idx: {6'd59, 6'd12, 6'd8, 6'd0},
                expv: {32'h706c631e, 32'ha8b09c1a, 32'h9ba35411, 32'h603deb10}};
    vecs[3] = vecs[0];
    vecs[3].size = 3'b111;
    vecs[4] = vecs[0];
    vecs[4].size = 3'b000;

    rst = 1'b1; start = 1'b0; key_size = 3'b001; key_in = '0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset key_exp", orFrom(0), 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int t = 0; t < 5; t++) runVec(vecs[t], t);

    // A.3 running; a start with the A.1 key at cycle 10 must be ignored.
    pulseStart(3'b100, K3);
    cyc = 0; doneCnt = 0; doneAt = 0;
    while (cyc < 80) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) begin doneCnt++; doneAt = cyc; end
      if (cyc == 10) begin start = 1'b1; key_size = 3'b001; key_in = K1; end
      if (cyc == 11) start = 1'b0;
    end
    check("ignored start done count", doneCnt, 32'd1);
    check("ignored start done cycle", doneAt, 32'd53);
    check("ignored start w[59]", getWord(59), 32'h706c631e);
    check("ignored start w[8]", getWord(8), 32'h9ba35411);

    // Reset during an A.1 run, then a clean A.2 run.
    pulseStart(3'b001, K1);
    repeat (19) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    check("midrun rst busy", 32'(busy), 32'd0);
    check("midrun rst done", 32'(done), 32'd0);
    check("midrun rst key_exp", orFrom(0), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done) begin
        compared++; mismatched++;
        $display("FAIL midrun rst spurious done: got 1, expected 0");
      end
    end
    runVec(vecs[1], 10);

    // start held high: back-to-back runs with one idle cycle between them.
    @(negedge clk);
    key_size = 3'b001; key_in = K1; start = 1'b1;
    cyc = 0; doneCnt = 0; doneAt = 0;
    while (cyc < 100 && doneCnt < 2) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) begin
        doneCnt++;
        if (doneCnt == 1) doneAt = cyc;
        else check("back-to-back spacing", cyc - doneAt, 32'd43);
      end
    end
    start = 1'b0;
    check("back-to-back done count", doneCnt, 32'd2);
    check("back-to-back w[43]", getWord(43), 32'hb6630ca6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
